// File: rtl/qam_tap_capture_ctrl.sv
// Capture sequencer for the QAM-16 debug taps: grabs a length- or gap-bounded
// frame from one selected tap into a small FIFO and streams it out valid/ready.
module qam_tap_capture_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_CYCLES = 6,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic                  start,
  input  logic [1:0]            tap_sel,
  input  logic [LEN_WIDTH-1:0]  cap_len,
  input  logic                  demod_valid,
  input  logic [DATA_WIDTH-1:0] demod_i,
  input  logic [DATA_WIDTH-1:0] demod_q,
  input  logic                  demult_valid,
  input  logic [DATA_WIDTH-1:0] demult_i,
  input  logic [DATA_WIDTH-1:0] demult_q,
  input  logic                  defilter_valid,
  input  logic [DATA_WIDTH-1:0] defilter_i,
  input  logic [DATA_WIDTH-1:0] defilter_q,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_i,
  output logic [DATA_WIDTH-1:0] m_q,
  output logic [1:0]            m_tag,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  gap_end
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;
  localparam logic [AW:0]          PTR_ONE = 1;
  localparam logic [GW-1:0]        GAP_ONE = 1;
  localparam logic [GW-1:0]        GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_TERM, S_DRAIN} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] i;
    logic [DATA_WIDTH-1:0] q;
    logic                  last;
  } beat_t;

  state_t                state, state_nxt;
  logic [1:0]            tag_r;
  logic [LEN_WIDTH-1:0]  len_r, cnt;
  logic [GW-1:0]         gapcnt;
  beat_t                 mem [FIFO_DEPTH];
  beat_t                 wr_beat, rd_beat;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  full, empty, rd_en, wr_en, can_wr;
  logic                  sel_valid, is_last, gap_hit, capturing;
  logic [DATA_WIDTH-1:0] sel_i, sel_q;

  // Tap select mux; taps feed the FIFO write path unregistered.
  always_comb begin
    sel_valid = demod_valid;
    sel_i     = demod_i;
    sel_q     = demod_q;
    case (tag_r)
      2'd1: begin sel_valid = demult_valid;   sel_i = demult_i;   sel_q = demult_q;   end
      2'd2: begin sel_valid = defilter_valid; sel_i = defilter_i; sel_q = defilter_q; end
      default: ;
    endcase
  end

  assign is_last   = (len_r != '0) && ((cnt + LEN_ONE) == len_r);
  assign gap_hit   = (gapcnt == GAP_LAST);
  assign capturing = (state == S_ARM || state == S_CAPTURE) && sel_valid;

  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en  = !empty && m_ready;
  assign can_wr = !full || rd_en;
  assign rd_beat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_ARM;
      S_ARM, S_CAPTURE: begin
        if (sel_valid) begin
          if (is_last) state_nxt = can_wr ? S_DRAIN : S_TERM;
          else         state_nxt = S_CAPTURE;
        end else if (state == S_CAPTURE && gap_hit) begin
          state_nxt = S_TERM;
        end
      end
      S_TERM:  if (can_wr) state_nxt = S_DRAIN;
      S_DRAIN: if (rd_en && rd_beat.last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    wr_en   = 1'b0;
    wr_beat = '{i: sel_i, q: sel_q, last: is_last};
    if (state == S_TERM) begin
      wr_en   = can_wr;
      wr_beat = '{i: '0, q: '0, last: 1'b1};
    end else if (capturing) begin
      wr_en = can_wr;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      tag_r    <= '0;
      len_r    <= '0;
      cnt      <= '0;
      gapcnt   <= '0;
      overflow <= 1'b0;
      gap_end  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_DRAIN) && rd_en && rd_beat.last;
      if (state == S_IDLE && start) begin
        tag_r    <= (tap_sel == 2'd3) ? 2'd0 : tap_sel;
        len_r    <= cap_len;
        cnt      <= '0;
        gapcnt   <= '0;
        overflow <= 1'b0;
        gap_end  <= 1'b0;
      end else if (capturing) begin
        cnt    <= cnt + LEN_ONE;
        gapcnt <= '0;
        if (!can_wr) overflow <= 1'b1;
      end else if (state == S_CAPTURE) begin
        gapcnt <= gapcnt + GAP_ONE;
        if (gap_hit) gap_end <= 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_beat;
  end

  // Gate read data so outputs sit at zero whenever nothing is buffered.
  assign m_valid = !empty;
  assign m_i     = m_valid ? rd_beat.i : '0;
  assign m_q     = m_valid ? rd_beat.q : '0;
  assign m_last  = m_valid && rd_beat.last;
  assign m_tag   = tag_r;
endmodule

// File: doc/qam_tap_capture_ctrl.md
# qam_tap_capture_ctrl

Capture sequencer for the QAM-16 demodulator debug taps. It takes the demodulator (demod), de-multiplier (demult) and de-filter (defilter) I/Q tap streams and, on command, captures a bounded frame from one selected tap. The frame is buffered and emitted as a single valid/ready stream to the export/readback path. It replaces free-running file dumps with a deterministic, length-controlled capture that ends cleanly on data gaps.

## Interface
- DATA_WIDTH, 16: tap sample width; narrower taps are sign-extended outside this block.
- LEN_WIDTH, 16: width of cap_len and the sample counter.
- GAP_CYCLES, 6: consecutive invalid cycles on the selected tap that end a capture.
- FIFO_DEPTH, 16: output buffer depth, in entries; must be a power of 2.

- axi_clk  in  1  sole clock; all logic is on the rising edge.
- axi_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle capture command; ignored unless busy=0.
- tap_sel  in  2  tap select: 0=demod, 1=demult, 2=defilter. 3 is reserved and is treated as 0. Latched at start.
- cap_len  in  LEN_WIDTH  number of samples to capture; 0 means unlimited (the capture ends on a gap only). Latched at start.
- demod_valid, demult_valid, defilter_valid  in  1 each  tap qualifiers.
- demod_i/q, demult_i/q, defilter_i/q  in  DATA_WIDTH each  signed tap samples.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_i, m_q  out  DATA_WIDTH  signed captured sample.
- m_tag  out  2  latched tap_sel.
- m_last  out  1  marks the final beat of a frame.
- busy  out  1  high from the start edge until the frame is fully drained.
- done  out  1  one-cycle pulse when the last beat is accepted.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full. Cleared by the next accepted start.
- gap_end  out  1  sticky; the frame ended on a gap rather than on cap_len. Cleared by the next accepted start.

## Operation
- States: IDLE, ARM, CAPTURE, TERM, DRAIN.
- IDLE: when start=1, latch tap_sel and cap_len, clear cnt, overflow and gap_end, and go to ARM. busy=1 from the next cycle.
- ARM: wait for the selected valid. Gap counting is not active in ARM. The first valid cycle is a captured sample; go to CAPTURE.
- CAPTURE behaviour on each cycle where the selected valid=1:
  - Write {i, q, last} to the FIFO and increment cnt.
  - last=1 when cap_len≠0 and cnt+1==cap_len; after that write, go to DRAIN.
  - If the FIFO is full, drop the sample and set overflow, but still increment cnt. If that dropped sample was the last one, go to TERM instead of DRAIN.
- CAPTURE behaviour on each cycle where the selected valid=0:
  - Increment gapcnt. Any valid cycle resets gapcnt.
  - When gapcnt reaches GAP_CYCLES, set gap_end and go to TERM.
- TERM: write a terminator beat (i=q=0, last=1) as soon as the FIFO has space, then go to DRAIN. The terminator is never dropped.
- DRAIN: when the m_last beat is accepted (m_valid & m_ready), pulse done, clear busy and go to IDLE.
- Tap inputs are not registered before the FIFO write mux. FIFO entries are {i, q, last}; m_tag is driven from the latched register.
- FIFO: a write and a read in the same cycle are both allowed when the FIFO is full, because the read frees the slot in that same cycle. m_valid = FIFO not empty. Output data is stable while m_valid=1 and m_ready=0.
- Unselected taps are ignored completely.
- start while busy=1: ignored, with no effect on status.
- Reset, including mid-frame: state=IDLE, FIFO emptied, all counters cleared. All outputs go to 0: m_valid, m_i, m_q, m_tag, m_last, busy, done, overflow, gap_end.

## Timing
- start at edge k: ARM is active at k+1. A selected valid sampled at edge k+1 or later is the first possible capture.
- Sample accepted at edge n appears on m_* with m_valid=1 after edge n, i.e. in cycle n+1, provided the FIFO was empty. Latency is 1 cycle.
- Throughput: 1 sample per cycle in and 1 per cycle out.
- Gap end: the GAP_CYCLES-th consecutive invalid cycle moves the block to TERM at that edge. The terminator is written on the next edge if there is space.
- done is asserted in the cycle after the edge that accepts the m_last beat. busy falls in that same cycle.

## Test plan
- Length capture: tap_sel=1, cap_len=8, demult_valid continuous with values 1..8 and m_ready=1. Expect 8 beats with m_i=1..8, m_tag=1, m_last on value 8, done once, gap_end=0, overflow=0.
- Gap termination: cap_len=0, defilter_valid high for 5 samples then low. Expect 5 data beats plus a terminator (0,0,last). The terminator appears 7 cycles after the last valid. gap_end=1.
- Short gap: a 5-cycle valid drop mid-stream (GAP_CYCLES=6) does not end the frame. gapcnt restarts and the total beat count equals cap_len.
- Backpressure/overflow: m_ready=0 and cap_len=20 with continuous valid. Expect the first 16 samples buffered and samples 17..20 dropped, overflow=1, then a terminator. Releasing m_ready drains 17 beats in order.
- Busy/start: a start during CAPTURE has no effect. A start in the cycle after done begins a new frame with overflow and gap_end cleared.
- Reset mid-frame: assert axi_rst after 3 captured beats. Expect all outputs 0 immediately (asynchronously), the FIFO empty, and a subsequent start behaving as from power-up.
